// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial transmitter. A WIDTH-bit word is taken over a
// valid/ready handshake and shifted out one bit per clock on a registered
// serial line, with registered framing strobes (data valid, start of frame,
// busy). A word can be accepted in the final bit cycle of the current frame,
// so frames can run back-to-back with no idle cycle between them.
//
// Optional feature:
//   BIT_SERIALIZER_PARITY_EN - when defined, an even-parity bit (XOR of the
//   accepted word) is appended after the last data bit, so a frame lasts
//   WIDTH+1 cycles. When undefined, the parity state and its logic are not
//   built, and a frame lasts exactly WIDTH cycles.
//
// Parameters:
//   WIDTH      data word width, 2..32
//   LSB_FIRST  1: bit 0 is sent first, 0: bit WIDTH-1 is sent first
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset (release synchronously)
//   i_data      word to send, sampled only on an accept edge
//   i_valid     producer has a word on i_data
//   o_ready     a word can be accepted this cycle (combinational)
//   o_sd        serial data (registered)
//   o_sd_valid  o_sd carries a frame bit (registered)
//   o_sof       o_sd is the first data bit of a frame (registered)
//   o_busy      a frame is in progress (registered)
// ---------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_sd,
  output logic             o_sd_valid,
  output logic             o_sof,
  output logic             o_busy
);

  // The counter holds the number of data bits still to be sent, including
  // the one being sent in the current cycle, so it runs WIDTH down to 1.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef BIT_SERIALIZER_PARITY_EN
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
`else
    ST_SHIFT  = 2'd1
`endif
  } state_e;

  // Even parity over a whole accepted word.
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  // Bit of the shift register that goes out in the current cycle.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    logic b;
    if (LSB_FIRST) begin
      b = w[0];
    end else begin
      b = w[WIDTH-1];
    end
    return b;
  endfunction

  // Shift register after the head bit has been sent; vacated bits fill
  // with zero.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    if (LSB_FIRST) begin
      r = {1'b0, w[WIDTH-1:1]};
    end else begin
      r = {w[WIDTH-2:0], 1'b0};
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par_q,   par_d;
`endif
  logic             sd_q,       sd_d;
  logic             sd_valid_q, sd_valid_d;
  logic             sof_q,      sof_d;
  logic             busy_q,     busy_d;

  logic             ready;
  logic             accept;
  logic             last_bit;

  assign last_bit = (cnt_q == CNT_ONE);
  assign accept   = i_valid & ready;

  // Ready in IDLE and in the final bit cycle of a frame only.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
      end
      ST_SHIFT: begin
`ifdef BIT_SERIALIZER_PARITY_EN
        // With parity the last cycle of the frame is the parity cycle.
        ready = 1'b0;
`else
        ready = last_bit;
`endif
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        ready = 1'b1;
      end
`endif
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign o_ready = ready;

  // Next state, shift register, counter and parity bit.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          shreg_d = i_data;
          cnt_d   = CNT_FULL;
`ifdef BIT_SERIALIZER_PARITY_EN
          par_d   = even_parity(i_data);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_d = ST_PARITY;
          shreg_d = '0;
          cnt_d   = '0;
`else
          // Same-edge accept chains straight into the next frame.
          if (accept) begin
            state_d = ST_SHIFT;
            shreg_d = i_data;
            cnt_d   = CNT_FULL;
          end else begin
            state_d = ST_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
          end
`endif
        end else begin
          state_d = ST_SHIFT;
          shreg_d = shift_one(shreg_q);
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        if (accept) begin
          state_d = ST_SHIFT;
          shreg_d = i_data;
          cnt_d   = CNT_FULL;
          par_d   = even_parity(i_data);
        end else begin
          state_d = ST_IDLE;
          shreg_d = '0;
          cnt_d   = '0;
          par_d   = 1'b0;
        end
      end
`endif
      default: begin
        // Unreachable encodings recover to a clean idle.
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d   = 1'b0;
`endif
      end
    endcase
  end

  // Output register inputs: the bit chosen in this state cycle appears on
  // the line after the next edge, which gives the one-edge accept latency.
  always_comb begin
    sd_d       = 1'b0;
    sd_valid_d = 1'b0;
    sof_d      = 1'b0;
    busy_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sd_d       = 1'b0;
        sd_valid_d = 1'b0;
        sof_d      = 1'b0;
        busy_d     = 1'b0;
      end
      ST_SHIFT: begin
        sd_d       = head_bit(shreg_q);
        sd_valid_d = 1'b1;
        sof_d      = (cnt_q == CNT_FULL);
        busy_d     = 1'b1;
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        sd_d       = par_q;
        sd_valid_d = 1'b1;
        sof_d      = 1'b0;
        busy_d     = 1'b1;
      end
`endif
      default: begin
        sd_d       = 1'b0;
        sd_valid_d = 1'b0;
        sof_d      = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q      <= 1'b0;
`endif
      sd_q       <= 1'b0;
      sd_valid_q <= 1'b0;
      sof_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q      <= par_d;
`endif
      sd_q       <= sd_d;
      sd_valid_q <= sd_valid_d;
      sof_q      <= sof_d;
      busy_q     <= busy_d;
    end
  end

  assign o_sd       = sd_q;
  assign o_sd_valid = sd_valid_q;
  assign o_sof      = sof_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer
//
// Two serializers (LSB-first and MSB-first) share one producer. A reference
// model keeps, per instance, a queue of the bits that have been accepted but
// not yet shown on the line. Each accepted word pushes its frame; each clock
// edge pops one entry onto the expected line. The block can take a word
// whenever at most one bit is still pending.
// ---------------------------------------------------------------------------
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] i_data;
  logic         i_valid;

  logic rdy_l, sd_l, sdv_l, sof_l, busy_l;
  logic rdy_m, sd_m, sdv_m, sof_m, busy_m;

  int checks   = 0;
  int failures = 0;

  // Pending line entries: {sof, sd}.
  logic [1:0] q_lsb[$];
  logic [1:0] q_msb[$];
  logic       last_acc;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rdy_l), .o_sd(sd_l), .o_sd_valid(sdv_l), .o_sof(sof_l),
    .o_busy(busy_l)
  );

  bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rdy_m), .o_sd(sd_m), .o_sd_valid(sdv_m), .o_sof(sof_m),
    .o_busy(busy_m)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Queue the frame of an accepted word for both bit orders.
  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      q_lsb.push_back({(i == 0), w[i]});
      q_msb.push_back({(i == 0), w[W-1-i]});
    end
`ifdef BIT_SERIALIZER_PARITY_EN
    q_lsb.push_back({1'b0, ^w});
    q_msb.push_back({1'b0, ^w});
`endif
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sd_l"},   sd_l,   1'b0);
    chk({tag, "_sdv_l"},  sdv_l,  1'b0);
    chk({tag, "_sof_l"},  sof_l,  1'b0);
    chk({tag, "_busy_l"}, busy_l, 1'b0);
    chk({tag, "_rdy_l"},  rdy_l,  1'b1);
    chk({tag, "_sd_m"},   sd_m,   1'b0);
    chk({tag, "_sdv_m"},  sdv_m,  1'b0);
    chk({tag, "_busy_m"}, busy_m, 1'b0);
    chk({tag, "_rdy_m"},  rdy_m,  1'b1);
  endtask

  // One clock: check ready mid-cycle, advance the model, check the line.
  task automatic cycle();
    logic       exp_rdy;
    logic       exp_v;
    logic [1:0] e_l;
    logic [1:0] e_m;
    @(negedge clk);
    exp_rdy = (q_lsb.size() <= 1);
    chk("ready_lsb", rdy_l, exp_rdy);
    chk("ready_msb", rdy_m, exp_rdy);
    last_acc = i_valid & exp_rdy;
    @(posedge clk);
    #1;
    if (q_lsb.size() > 0) begin
      e_l   = q_lsb.pop_front();
      e_m   = q_msb.pop_front();
      exp_v = 1'b1;
    end else begin
      e_l   = 2'b00;
      e_m   = 2'b00;
      exp_v = 1'b0;
    end
    if (last_acc) push_word(i_data);
    chk("sd_lsb",    sd_l,   e_l[0]);
    chk("sof_lsb",   sof_l,  e_l[1]);
    chk("valid_lsb", sdv_l,  exp_v);
    chk("busy_lsb",  busy_l, exp_v);
    chk("sd_msb",    sd_m,   e_m[0]);
    chk("sof_msb",   sof_m,  e_m[1]);
    chk("valid_msb", sdv_m,  exp_v);
    chk("busy_msb",  busy_m, exp_v);
  endtask

  task automatic idle_cycles(input int n);
    i_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present a word and hold it until the model says it was taken.
  task automatic send(input logic [W-1:0] w);
    int n;
    n       = 0;
    i_valid = 1'b1;
    i_data  = w;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 40);
    i_valid = 1'b0;
  endtask

  initial begin
    logic hold;
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_data   = '0;
    last_acc = 1'b0;
    hold     = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    idle_cycles(2);

    // Basic frames, both bit orders.
    send(8'hA5);
    idle_cycles(11);
    send(8'h80);
    idle_cycles(11);

    // Back-to-back with i_valid held across both words.
    send(8'hA5);
    send(8'h3C);
    idle_cycles(11);

    // Stall: word arrives in the 3rd cycle of a frame and is held.
    send(8'hA5);
    cycle();
    send(8'hFF);
    idle_cycles(11);

    // Parity-relevant words (plain frames without the parity option).
    send(8'h07);
    idle_cycles(11);

    // Reset in the middle of a frame, after bit 4 is on the line.
    send(8'hA5);
    repeat (4) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    q_lsb.delete();
    q_msb.delete();
    @(posedge clk);
    #1;
    chk_idle_outputs("inreset");
    rst_n = 1'b1;
    send(8'h01);
    idle_cycles(11);

    // Randomized traffic; a word that is not yet taken stays on the bus.
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        i_valid = ($urandom_range(0, 99) < 60);
        i_data  = 8'($urandom);
      end
      cycle();
      hold = i_valid & ~last_acc;
    end
    idle_cycles(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial transmitter that pairs with the single-bit registered capture path. It accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per clock on a registered serial line with framing strobes. The downstream flip-flop or deserializer samples one bit per rising edge. It sits between a word-wide producer and any single-bit sampled link in the design.

## Interface
- WIDTH, 8: data word width; legal range 2..32.
- LSB_FIRST, 1: 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.

- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_data  input  WIDTH  word to send; sampled only on an accept edge.
- i_valid  input  1  producer has a word on i_data.
- o_ready  output  1  block can accept a word this cycle (combinational from state and counter).
- o_sd  output  1  serial data, registered.
- o_sd_valid  output  1  o_sd carries a frame bit this cycle, registered.
- o_sof  output  1  o_sd is the first bit of a frame, registered.
- o_busy  output  1  frame in progress (state != IDLE), registered.

## Operation
- Accept: rising edge where i_valid && o_ready. i_data is copied into the shift register, and the bit counter is loaded.
- States:
  - IDLE: o_ready=1. Accept moves to SHIFT.
  - SHIFT: one data bit per cycle. After the last data bit, moves to PARITY if configured. Otherwise it moves to SHIFT (new frame) on a same-edge accept, or to IDLE.
  - PARITY: one cycle. Moves to SHIFT on a same-edge accept, else to IDLE.
- o_ready is 1 in IDLE and during the final bit cycle of a frame (last data bit, or the parity bit when enabled). This allows gapless back-to-back frames. o_ready is 0 in all other SHIFT cycles. A held i_valid is ignored while o_ready=0; the word is not lost and is accepted on the next o_ready cycle.
- Shift direction follows LSB_FIRST. Counter width is $clog2(WIDTH+1), and it counts remaining bits down to 1.
- o_sof=1 only on the first data bit of each frame, including the first bit of a back-to-back frame.
- Reset (asserted at any time, including mid-frame): asynchronously forces IDLE and clears the shift register and counter. Outputs take these values: o_sd=0, o_sd_valid=0, o_sof=0, o_busy=0, o_ready=1. The partial frame is dropped, and no further bits are emitted.
- When idle, o_sd=0 and o_sd_valid=0.

## Timing
- Latency: accept at edge N puts bit 0 of the frame on o_sd at edge N+1, with o_sd_valid=1 and o_sof=1.
- A frame occupies WIDTH consecutive cycles, or WIDTH+1 with parity. o_sd_valid stays 1 for the whole frame.
- Back-to-back: an accept in the final bit cycle puts the next frame's first bit on o_sd on the very next edge, with no idle cycle.
- o_busy rises at edge N+1 and falls on the edge after the final bit if no new accept occurred.
- Reset deassertion is not synchronized inside the block; it must be released synchronously to i_clk at integration.

## Configuration
- BIT_SERIALIZER_PARITY_EN defined: an even-parity bit is appended after the last data bit.
  - The parity bit is the XOR of all WIDTH bits of the accepted word.
  - During the parity cycle: o_sd_valid=1 and o_sof=0.
  - Frame length becomes WIDTH+1 cycles.
  - o_ready is high only in the parity cycle of the frame.
- BIT_SERIALIZER_PARITY_EN undefined: the PARITY state and its logic are absent, and frames are exactly WIDTH cycles.

## Test plan
- Basic frame (WIDTH=8, LSB_FIRST=1): single accept of 8'hA5 -> o_sd = 1,0,1,0,0,1,0,1 on 8 consecutive edges. o_sof is high only on the first edge, o_sd_valid is high for 8 cycles, then both return to 0.
- MSB first (LSB_FIRST=0): 8'hA5 -> o_sd = 1,0,1,0,0,1,0,1. Then 8'h80 -> 1,0,0,0,0,0,0,0.
- Back-to-back: i_valid held high with 8'hA5 followed by 8'h3C -> 16 contiguous valid bits with no gap and o_sof on bits 1 and 9. o_ready is high for only one cycle per frame while busy.
- Stall: i_valid pulses with 8'hFF in the 3rd cycle of a frame and is held -> it is not accepted until the final-bit cycle, and 8'hFF is sent intact afterward.
- Reset mid-frame: assert i_rst_n=0 after bit 4 of 8'hA5 -> outputs go to o_sd=0, o_sd_valid=0, o_busy=0, o_ready=1 immediately. After release, a new accept of 8'h01 produces a clean frame.
- Parity (BIT_SERIALIZER_PARITY_EN): 8'hA5 -> 9th bit is 0. 8'h07 -> 9th bit is 1. Frame is 9 valid cycles.
